mdio_frame_master: RTL and testbench
====================================

# mdio_frame_master

Parametrised Clause-22 MDIO management master that serialises single read/write commands onto the PHY management bus with a generated MDC clock. It replaces the fixed three-write boot sequencer. It accepts commands over a valid/ready handshake from the MAC control plane and returns read data and a status response. It sits between the Ethernet IP register/boot logic and the PHY MDIO pad (tri-state buffer outside this block).

## Interface
- CLK_DIV, 4, clk cycles per MDC half-period (≥1)
- PREAMBLE_BITS, 32, preamble ones before ST (0 = preamble suppression)
- GAP_BITS, 8, idle MDC bit-times after each frame
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block idle, command accepted on valid&&ready
- cmd_read  in  1  1 = read, 0 = write
- cmd_phy_addr  in  5  PHYAD
- cmd_reg_addr  in  5  REGAD
- cmd_wdata  in  16  write data
- rsp_valid  out  1  one-cycle pulse, command complete
- rsp_rdata  out  16  read data (0 for writes)
- rsp_err  out  1  read with no PHY turnaround response, or read disabled
- mdc  out  1  management clock
- mdio_o  out  1  MDIO drive value
- mdio_t  out  1  1 = tri-state (released), 0 = driving
- mdio_i  in  1  MDIO pad input

## Operation
- States: IDLE, PREAMBLE, HEADER, TA, DATA, RESP, GAP.
- IDLE: cmd_ready=1, mdc=0, mdio_t=1. Accepting a command latches all fields and goes to PREAMBLE. If PREAMBLE_BITS=0, it goes to HEADER.
- PREAMBLE: PREAMBLE_BITS ones, mdio_t=0.
- HEADER: 14 bits MSB first: ST=01, OP (01 write / 10 read), PHYAD[4:0], REGAD[4:0]. mdio_t=0.
- TA, write: drive 1 then 0. TA, read: mdio_t=1 for both bits. Sample mdio_i on the second TA rising MDC edge; a sampled value of 1 sets rsp_err.
- DATA, write: drive cmd_wdata MSB first.
- DATA, read: mdio_t=1. Shift mdio_i in on each rising MDC edge, MSB first. All 16 bits are clocked even when rsp_err is set.
- RESP: one cycle, rsp_valid=1. rsp_rdata and rsp_err hold until the next accepted command.
- GAP: GAP_BITS×2×CLK_DIV cycles with mdc=0 and mdio_t=1, then IDLE.
- cmd_valid while not IDLE is ignored, because cmd_ready=0.

## Timing
- Reset values: cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mdc=0, mdio_o=0, mdio_t=1. The state goes to IDLE and the divider clears.
- Reset asserted mid-frame returns these values asynchronously. No response is issued.
- Bit time is 2×CLK_DIV clk cycles: CLK_DIV with mdc low, then CLK_DIV with mdc high.
- mdio_o/mdio_t change only at bit start, which coincides with the mdc falling edge. mdio_i is sampled in the clk cycle where mdc rises.
- First preamble bit is driven in the cycle after acceptance.
- rsp_valid is asserted (PREAMBLE_BITS+32)×2×CLK_DIV+1 cycles after the acceptance edge.
- cmd_ready rises GAP_BITS×2×CLK_DIV cycles after rsp_valid.
- Counters: bit counter 7 bits (PREAMBLE_BITS ≤ 64); divider width $clog2(CLK_DIV).

## Configuration
- MDIO_READ_EN defined: read frames are supported as above.
- MDIO_READ_EN not defined: the TA/read-capture logic is compiled out.
  - Read commands are still accepted, but no bus activity occurs.
  - rsp_valid pulses in the cycle after acceptance with rsp_err=1 and rsp_rdata=0.
  - The block then returns directly to IDLE, with no gap.
  - Writes are unchanged.

## Structure
- Package mdio_pkg holds:
  - state enum
  - ST=2'b01, OP_WR=2'b01, OP_RD=2'b10, TA_WR=2'b10
  - field widths (PHYAD 5, REGAD 5, DATA 16, HEADER_BITS 14)
- Sub-module mdio_clk_div generates mdc plus single-cycle rise/fall strobes.
  - Enabled by the FSM; held with mdc=0 when disabled.

## Test plan
- Write, CLK_DIV=2, PREAMBLE_BITS=32: phy 0x01, reg 0x00, data 0x1140 → mdio_o stream is 32 ones, then 0101 00001 00000 10 0001000101000000. mdio_t=0 throughout. rsp_valid at cycle 257, rsp_err=0.
- Read, PHY model drives TA=0 and data 0x796D → mdio_t=1 from TA onward, rsp_rdata=0x796D, rsp_err=0.
- Read with mdio_i held 1 (no PHY) → rsp_err=1, rsp_rdata=0xFFFF.
- PREAMBLE_BITS=0, write → ST is the first driven bit; rsp_valid at cycle 129 (CLK_DIV=2).
- Back-to-back: cmd_valid held with two commands → second is accepted only after the GAP; cmd_ready stays 0 during the frame.
- Reset pulsed mid-DATA → mdio_t=1 and mdc=0 immediately, no rsp_valid; the next command runs a full, correct frame. Without MDIO_READ_EN, a read gives rsp_err=1 one cycle after acceptance.

Source files
------------

// File: rtl/mdio_frame_master_pkg.sv
// mdio_pkg: FSM state encoding, Clause-22 frame constants, field widths
// and a helper that assembles the serial part of a management frame.
package mdio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        HEADER,
        TA,
        DATA,
        RESP,
        GAP
    } state_t;

    localparam logic [1:0] ST    = 2'b01;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] TA_WR = 2'b10;

    localparam int PHYAD_BITS  = 5;
    localparam int REGAD_BITS  = 5;
    localparam int DATA_BITS   = 16;
    localparam int HEADER_BITS = 14;
    localparam int TA_BITS     = 2;
    localparam int FRAME_BITS  = HEADER_BITS + TA_BITS + DATA_BITS;

    // Header, write turnaround and data, MSB first; for reads only the
    // header part is ever driven onto the bus.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic                  rd,
        input logic [PHYAD_BITS-1:0] phy,
        input logic [REGAD_BITS-1:0] regad,
        input logic [DATA_BITS-1:0]  data
    );
        return {ST, (rd ? OP_RD : OP_WR), phy, regad, TA_WR, data};
    endfunction

endpackage

// File: rtl/mdio_frame_master_clk_div.sv
// mdio_clk_div: MDC generator. Each half-period lasts CLK_DIV clk cycles.
// rise/fall are asserted in the clk cycle whose closing edge raises/lowers
// mdc. While disabled the divider is cleared and mdc is held low.
module mdio_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic mdc,
    output logic rise,
    output logic fall
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] cnt;
    logic          at_last;

    assign at_last = (cnt == LAST);
    assign rise    = en && at_last && !mdc;
    assign fall    = en && at_last && mdc;

    // Half-period counter and mdc toggle; restart low whenever disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            mdc <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            mdc <= 1'b0;
        end else if (at_last) begin
            cnt <= '0;
            mdc <= ~mdc;
        end else begin
            cnt <= cnt + DW'(1);
        end
    end

endmodule

// File: rtl/mdio_frame_master.sv
// mdio_frame_master: Clause-22 MDIO master, one read/write command per frame.
// Optional feature: define MDIO_READ_EN to build read frames (turnaround
// check and data capture). Without it a read is answered at once with
// rsp_err=1 and no bus activity; writes are identical in both builds.
module mdio_frame_master
    import mdio_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int PREAMBLE_BITS = 32,
    parameter int GAP_BITS      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_read,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_t,
    input  logic        mdio_i
);

    // RESP counts as the first idle cycle, so GAP itself lasts one cycle less.
    localparam int GAP_CYCLES = GAP_BITS * 2 * CLK_DIV;
    localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 2);

    localparam logic [6:0] PRE_LAST  = 7'(PREAMBLE_BITS - 1);
    localparam logic [6:0] HDR_LAST  = 7'(HEADER_BITS - 1);
    localparam logic [6:0] TA_LAST   = 7'(TA_BITS - 1);
    localparam logic [6:0] DATA_LAST = 7'(DATA_BITS - 1);

    localparam state_t FIRST_STATE = (PREAMBLE_BITS == 0) ? HEADER : PREAMBLE;
    localparam state_t RESP_NEXT   = (GAP_BITS == 0) ? IDLE : GAP;

    state_t                state;
    state_t                state_nxt;
    state_t                seg_next;
    logic [6:0]            bit_cnt;
    logic [6:0]            bit_cnt_nxt;
    logic [6:0]            seg_last;
    logic [FRAME_BITS-1:0] frame;
    logic                  is_read;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  accept;
    logic                  div_en;
    logic                  rise;
    logic                  fall;

    assign accept = (state == IDLE) && cmd_valid;
    assign div_en = (state == PREAMBLE) || (state == HEADER) ||
                    (state == TA) || (state == DATA);

    mdio_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk  (clk),
        .reset(reset),
        .en   (div_en),
        .mdc  (mdc),
        .rise (rise),
        .fall (fall)
    );

    // State and bit-within-segment counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    // Next state and pad/handshake outputs; bus segments advance at bit end.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        seg_last    = '0;
        seg_next    = IDLE;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        mdio_o      = 1'b0;
        mdio_t      = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    bit_cnt_nxt = '0;
`ifdef MDIO_READ_EN
                    state_nxt = FIRST_STATE;
`else
                    state_nxt = cmd_read ? RESP : FIRST_STATE;
`endif
                end
            end
            PREAMBLE: begin
                mdio_o   = 1'b1;
                mdio_t   = 1'b0;
                seg_last = PRE_LAST;
                seg_next = HEADER;
            end
            HEADER: begin
                mdio_o   = frame[FRAME_BITS-1];
                mdio_t   = 1'b0;
                seg_last = HDR_LAST;
                seg_next = TA;
            end
            TA: begin
                mdio_o   = is_read ? 1'b0 : frame[FRAME_BITS-1];
                mdio_t   = is_read;
                seg_last = TA_LAST;
                seg_next = DATA;
            end
            DATA: begin
                mdio_o   = is_read ? 1'b0 : frame[FRAME_BITS-1];
                mdio_t   = is_read;
                seg_last = DATA_LAST;
                seg_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
`ifdef MDIO_READ_EN
                state_nxt = RESP_NEXT;
`else
                state_nxt = is_read ? IDLE : RESP_NEXT;
`endif
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (fall) begin
            if (bit_cnt == seg_last) begin
                state_nxt   = seg_next;
                bit_cnt_nxt = '0;
            end else begin
                bit_cnt_nxt = bit_cnt + 7'd1;
            end
        end
    end

    // Command latch, frame shifter, gap timer and response capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_read   <= 1'b0;
            frame     <= '0;
            gap_cnt   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
            if (accept) begin
                is_read   <= cmd_read;
                frame     <= build_frame(cmd_read, cmd_phy_addr, cmd_reg_addr, cmd_wdata);
                rsp_rdata <= '0;
`ifdef MDIO_READ_EN
                rsp_err   <= 1'b0;
`else
                rsp_err   <= cmd_read;
`endif
            end else if (fall && (state == HEADER || state == TA || state == DATA)) begin
                frame <= {frame[FRAME_BITS-2:0], 1'b0};
            end
`ifdef MDIO_READ_EN
            if (rise && is_read && state == TA && bit_cnt == TA_LAST) begin
                rsp_err <= mdio_i;
            end
            if (rise && is_read && state == DATA) begin
                rsp_rdata <= {rsp_rdata[DATA_BITS-2:0], mdio_i};
            end
`endif
        end
    end

`ifdef MDIO_READ_EN
`else
    logic unused_read_inputs;
    assign unused_read_inputs = ^{rise, mdio_i};
`endif

endmodule

// File: tb/tb_mdio_frame_master.sv
// tb_mdio_frame_master: randomized frame checks against a cycle-level model
// of the MDIO waveform built from the frame rules. Two instances: the
// default 32-bit preamble and preamble suppression.
module tb_mdio_frame_master;

    localparam int CD = 2;
    localparam int G  = 4;
    localparam int P0 = 32;
`ifdef MDIO_READ_EN
    localparam bit READ_ON = 1'b1;
`else
    localparam bit READ_ON = 1'b0;
`endif

    typedef struct packed {
        logic        rd;
        logic [4:0]  phy;
        logic [4:0]  regad;
        logic [15:0] wdata;
    } cmd_t;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_read;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic        mdio_i;

    logic        cmd_valid0, cmd_ready0, rsp_valid0, rsp_err0, mdc0, mdio_o0, mdio_t0;
    logic        cmd_valid1, cmd_ready1, rsp_valid1, rsp_err1, mdc1, mdio_o1, mdio_t1;
    logic [15:0] rsp_rdata0, rsp_rdata1;

    logic        obs_ready, obs_rv, obs_err, obs_mdc, obs_o, obs_t;
    logic [15:0] obs_rdata;

    int cur_sel;
    int checks;
    int errors;

    assign cmd_valid0 = cmd_valid && (cur_sel == 0);
    assign cmd_valid1 = cmd_valid && (cur_sel == 1);
    assign obs_ready  = (cur_sel == 0) ? cmd_ready0 : cmd_ready1;
    assign obs_rv     = (cur_sel == 0) ? rsp_valid0 : rsp_valid1;
    assign obs_err    = (cur_sel == 0) ? rsp_err0   : rsp_err1;
    assign obs_rdata  = (cur_sel == 0) ? rsp_rdata0 : rsp_rdata1;
    assign obs_mdc    = (cur_sel == 0) ? mdc0       : mdc1;
    assign obs_o      = (cur_sel == 0) ? mdio_o0    : mdio_o1;
    assign obs_t      = (cur_sel == 0) ? mdio_t0    : mdio_t1;

    mdio_frame_master #(.CLK_DIV(CD), .PREAMBLE_BITS(P0), .GAP_BITS(G)) dut0 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
        .cmd_read(cmd_read), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
        .rsp_err(rsp_err0), .mdc(mdc0), .mdio_o(mdio_o0), .mdio_t(mdio_t0), .mdio_i(mdio_i)
    );

    mdio_frame_master #(.CLK_DIV(CD), .PREAMBLE_BITS(0), .GAP_BITS(G)) dut1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_read(cmd_read), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
        .rsp_err(rsp_err1), .mdc(mdc1), .mdio_o(mdio_o1), .mdio_t(mdio_t1), .mdio_i(mdio_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic cmd_t mk(input logic rd, input logic [4:0] phy,
                                input logic [4:0] regad, input logic [15:0] wdata);
        cmd_t c;
        c.rd = rd; c.phy = phy; c.regad = regad; c.wdata = wdata;
        return c;
    endfunction

    task automatic drive_cmd(input cmd_t c);
        cmd_read     = c.rd;
        cmd_phy_addr = c.phy;
        cmd_reg_addr = c.regad;
        cmd_wdata    = c.wdata;
    endtask

    // Offer a command and return at the falling edge where it is seen accepted.
    task automatic start_cmd(input cmd_t c, input string name);
        int w;
        @(negedge clk);
        drive_cmd(c);
        cmd_valid = 1'b1;
        w = 0;
        while (obs_ready !== 1'b1 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (obs_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s accept: cmd_ready=%b required 1 within 1000 cycles", name, obs_ready);
        end
    endtask

    // Check every cycle from acceptance to cmd_ready returning, against the
    // waveform predicted from the frame layout, acting as the PHY on reads.
    task automatic follow_frame(input cmd_t c, input bit present, input logic [15:0] phy_data,
                                input bit hold, input cmd_t nxt, input string name);
        logic        eo [0:127];
        logic        et [0:127];
        logic        pin[0:127];
        logic [13:0] hdr;
        logic [4:0]  act, expv, mask, bad_act, bad_exp;
        logic [15:0] exp_rdata;
        logic        exp_err;
        bit          bus;
        int          p, nbits, n_rsp, r_rdy, seen_rsp, bad_k, b, ph;
        p     = (cur_sel == 0) ? P0 : 0;
        bus   = !c.rd || READ_ON;
        nbits = p + 32;
        for (int i = 0; i < nbits; i++) begin
            eo[i] = 1'b1; et[i] = 1'b0; pin[i] = 1'b1;
        end
        hdr = {2'b01, (c.rd ? 2'b10 : 2'b01), c.phy, c.regad};
        for (int i = 0; i < 14; i++) eo[p+i] = hdr[13-i];
        for (int i = 0; i < 2; i++) begin
            et[p+14+i] = c.rd;
            eo[p+14+i] = (i == 0);
        end
        for (int i = 0; i < 16; i++) begin
            et[p+16+i] = c.rd;
            eo[p+16+i] = c.wdata[15-i];
        end
        if (c.rd && present) begin
            pin[p+15] = 1'b0;
            for (int i = 0; i < 16; i++) pin[p+16+i] = phy_data[15-i];
        end
        n_rsp     = bus ? nbits * 2 * CD + 1 : 1;
        r_rdy     = bus ? n_rsp + G * 2 * CD : n_rsp + 1;
        exp_rdata = (!c.rd || !bus) ? 16'h0000 : (present ? phy_data : 16'hFFFF);
        exp_err   = c.rd && (!bus || !present);
        seen_rsp  = 0;
        bad_k     = 0;
        bad_act   = '0;
        bad_exp   = '0;
        for (int k = 1; k <= r_rdy; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (hold) drive_cmd(nxt);
                else cmd_valid = 1'b0;
            end
            if (k < n_rsp) begin
                b      = (k - 1) / (2 * CD);
                ph     = (k - 1) % (2 * CD);
                mdio_i = pin[b];
                expv   = {1'b0, 1'b0, (ph >= CD), et[b], eo[b]};
                mask   = et[b] ? 5'b11110 : 5'b11111;
            end else begin
                mdio_i = 1'b1;
                expv   = {(k == n_rsp), (k == r_rdy), 1'b0, 1'b1, 1'b0};
                mask   = 5'b11110;
            end
            act = {obs_rv, obs_ready, obs_mdc, obs_t, obs_o};
            if (bad_k == 0 && ((act & mask) !== (expv & mask))) begin
                bad_k   = k;
                bad_act = act & mask;
                bad_exp = expv & mask;
            end
            if (obs_rv === 1'b1 && seen_rsp == 0) seen_rsp = k;
            if (k == n_rsp) begin
                checks += 2;
                if (obs_rdata !== exp_rdata) begin
                    errors++;
                    $display("[TB] FAIL %s rsp_rdata: got %h required %h", name, obs_rdata, exp_rdata);
                end
                if (obs_err !== exp_err) begin
                    errors++;
                    $display("[TB] FAIL %s rsp_err: got %b required %b", name, obs_err, exp_err);
                end
            end
            if (k == r_rdy) begin
                checks++;
                if (obs_rdata !== exp_rdata) begin
                    errors++;
                    $display("[TB] FAIL %s rdata_hold: got %h required %h", name, obs_rdata, exp_rdata);
                end
            end
        end
        checks += 2;
        if (bad_k != 0) begin
            errors++;
            $display("[TB] FAIL %s waveform cycle %0d: {rsp_valid,cmd_ready,mdc,mdio_t,mdio_o} got %b required %b",
                     name, bad_k, bad_act, bad_exp);
        end
        if (seen_rsp != n_rsp) begin
            errors++;
            $display("[TB] FAIL %s rsp_cycle: got %0d required %0d", name, seen_rsp, n_rsp);
        end
    endtask

    task automatic test_reset();
        cur_sel   = 0;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        mdio_i    = 1'b1;
        drive_cmd('0);
        repeat (3) @(negedge clk);
        checks += 8;
        if (cmd_ready0 !== 1'b1) begin errors++; $display("[TB] FAIL reset cmd_ready: got %b required 1", cmd_ready0); end
        if (rsp_valid0 !== 1'b0) begin errors++; $display("[TB] FAIL reset rsp_valid: got %b required 0", rsp_valid0); end
        if (rsp_rdata0 !== 16'h0) begin errors++; $display("[TB] FAIL reset rsp_rdata: got %h required 0000", rsp_rdata0); end
        if (rsp_err0 !== 1'b0) begin errors++; $display("[TB] FAIL reset rsp_err: got %b required 0", rsp_err0); end
        if (mdc0 !== 1'b0) begin errors++; $display("[TB] FAIL reset mdc: got %b required 0", mdc0); end
        if (mdio_o0 !== 1'b0) begin errors++; $display("[TB] FAIL reset mdio_o: got %b required 0", mdio_o0); end
        if (mdio_t0 !== 1'b1) begin errors++; $display("[TB] FAIL reset mdio_t: got %b required 1", mdio_t0); end
        if (cmd_ready1 !== 1'b1) begin errors++; $display("[TB] FAIL reset cmd_ready_nopre: got %b required 1", cmd_ready1); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        cmd_t c;
        cur_sel = 0;
        c = mk(1'b0, 5'h01, 5'h00, 16'h1140);
        start_cmd(c, "write_vec");
        follow_frame(c, 1'b0, 16'h0, 1'b0, '0, "write_vec");
    endtask

    task automatic test_read();
        cmd_t c;
        cur_sel = 0;
        c = mk(1'b1, 5'h03, 5'h02, 16'h0);
        start_cmd(c, "read_phy");
        follow_frame(c, 1'b1, 16'h796D, 1'b0, '0, "read_phy");
        c = mk(1'b1, 5'h1F, 5'h11, 16'h0);
        start_cmd(c, "read_nophy");
        follow_frame(c, 1'b0, 16'h0, 1'b0, '0, "read_nophy");
    endtask

    task automatic test_no_preamble();
        cmd_t c;
        cur_sel = 1;
        c = mk(1'b0, 5'($urandom), 5'($urandom), 16'($urandom));
        start_cmd(c, "nopre_write");
        follow_frame(c, 1'b0, 16'h0, 1'b0, '0, "nopre_write");
        c = mk(1'b1, 5'($urandom), 5'($urandom), 16'h0);
        start_cmd(c, "nopre_read");
        follow_frame(c, 1'b1, 16'($urandom), 1'b0, '0, "nopre_read");
        cur_sel = 0;
    endtask

    task automatic test_random();
        cmd_t c;
        cur_sel = 0;
        for (int i = 0; i < 6; i++) begin
            c = mk(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
            start_cmd(c, "random");
            follow_frame(c, 1'($urandom), 16'($urandom), 1'b0, '0, "random");
        end
    endtask

    task automatic test_back_to_back();
        cmd_t a, b;
        cur_sel = 0;
        a = mk(1'b0, 5'($urandom), 5'($urandom), 16'($urandom));
        b = mk(1'b1, 5'($urandom), 5'($urandom), 16'h0);
        start_cmd(a, "b2b_first");
        follow_frame(a, 1'b0, 16'h0, 1'b1, b, "b2b_first");
        follow_frame(b, 1'b1, 16'($urandom), 1'b0, '0, "b2b_second");
    endtask

    task automatic test_reset_mid_frame();
        cmd_t c;
        int   pulses;
        cur_sel = 0;
        c = mk(1'b0, 5'h05, 5'h0A, 16'hA5C3);
        start_cmd(c, "midreset");
        for (int k = 1; k <= 223; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
        end
        checks++;
        if (mdc0 !== 1'b1) begin errors++; $display("[TB] FAIL midreset mdc_before: got %b required 1", mdc0); end
        reset = 1'b0;
        #1;
        checks += 4;
        if (mdc0 !== 1'b0) begin errors++; $display("[TB] FAIL midreset mdc: got %b required 0", mdc0); end
        if (mdio_t0 !== 1'b1) begin errors++; $display("[TB] FAIL midreset mdio_t: got %b required 1", mdio_t0); end
        if (cmd_ready0 !== 1'b1) begin errors++; $display("[TB] FAIL midreset cmd_ready: got %b required 1", cmd_ready0); end
        if (rsp_valid0 !== 1'b0) begin errors++; $display("[TB] FAIL midreset rsp_valid: got %b required 0", rsp_valid0); end
        repeat (3) @(negedge clk);
        reset  = 1'b1;
        pulses = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (rsp_valid0 === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("[TB] FAIL midreset no_response: got %0d pulses required 0", pulses); end
        c = mk(1'b0, 5'($urandom), 5'($urandom), 16'($urandom));
        start_cmd(c, "after_reset");
        follow_frame(c, 1'b0, 16'h0, 1'b0, '0, "after_reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write();
        test_read();
        test_no_preamble();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
